// File: rtl/alu_byte_seq.sv
// alu_byte_seq: byte-serial sequencer for a shared 8-bit ALU.
// Builds BYTES*8-bit ADD/SUB/AND/OR/XOR with per-byte carry fix-up passes.
module alu_byte_seq #(
    parameter int BYTES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [BYTES*8-1:0] req_a,
    input  logic [BYTES*8-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BYTES*8-1:0] rsp_result,
    output logic               rsp_carry,
    output logic               busy,
    output logic [3:0]         alu_select,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    input  logic [7:0]         alu_out
);
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, MAIN, FIX, RESP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           op;
    logic [BYTES-1:0][7:0] a_q;
    logic [BYTES-1:0][7:0] b_q;
    logic [BYTES-1:0][7:0] res_q;
    logic [IW-1:0]        idx;
    logic                 cin;
    logic                 main_c_q;
    logic                 carry_q;

    logic                 is_add;
    logic                 is_sub;
    logic                 is_arith;
    logic                 is_sup;
    logic                 last;
    logic [7:0]           a_i;
    logic [7:0]           b_i;
    logic [7:0]           r_i;
    logic                 main_c;
    logic                 fix_c;
    logic                 byte_c;
    logic [7:0]           byte_d;

    assign is_add   = (op == 3'd0);
    assign is_sub   = (op == 3'd1);
    assign is_arith = is_add | is_sub;
    assign is_sup   = (op <= 3'd4);
    assign last     = (idx == LAST);
    assign a_i      = a_q[idx];
    assign b_i      = b_q[idx];
    assign r_i      = res_q[idx];

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, ALU drive and per-byte carry derivation
    always_comb begin
        state_nxt  = state;
        alu_select = 4'd0;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        main_c     = 1'b0;
        fix_c      = 1'b0;
        byte_c     = 1'b0;
        byte_d     = 8'h00;
        unique case (state)
            IDLE: begin
                if (req_valid) state_nxt = MAIN;
            end
            MAIN: begin
                if (is_sup) begin
                    alu_select = {1'b0, op};
                    alu_a      = a_i;
                    alu_b      = b_i;
                    byte_d     = alu_out;
                end
                main_c = (is_add && (alu_out < a_i)) ||
                         (is_sub && (a_i < b_i));
                byte_c = main_c;
                if (is_arith && cin) state_nxt = FIX;
                else if (last)       state_nxt = RESP;
                else                 state_nxt = MAIN;
            end
            FIX: begin
                alu_select = {1'b0, op};
                alu_a      = r_i;
                alu_b      = 8'h01;
                byte_d     = alu_out;
                fix_c      = is_add ? (alu_out == 8'h00)
                                    : (alu_out == 8'hFF);
                byte_c     = main_c_q | fix_c;
                state_nxt  = last ? RESP : MAIN;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, result bytes and carry chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            idx      <= '0;
            cin      <= 1'b0;
            main_c_q <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op      <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        res_q   <= '0;
                        idx     <= '0;
                        cin     <= 1'b0;
                        carry_q <= 1'b0;
                    end
                end
                MAIN: begin
                    res_q[idx] <= byte_d;
                    if (state_nxt == FIX) begin
                        main_c_q <= main_c;
                    end else begin
                        cin <= byte_c;
                        if (last) carry_q <= byte_c;
                        else      idx     <= idx + 1'b1;
                    end
                end
                FIX: begin
                    res_q[idx] <= byte_d;
                    cin        <= byte_c;
                    if (last) carry_q <= byte_c;
                    else      idx     <= idx + 1'b1;
                end
                RESP: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_byte_seq.sv
// tb_alu_byte_seq: directed bench with an arithmetic reference model.
// Includes a behavioural 8-bit ALU attached to the sequencer.
module tb_alu_byte_seq;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [15:0] req_a = 16'h0;
    logic [15:0] req_b = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        busy;
    logic [3:0]  alu_select;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] exp_res = 16'h0;
    logic        exp_c = 1'b0;
    logic        in_flight = 1'b0;
    logic        in_resp = 1'b0;

    alu_byte_seq #(.BYTES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .busy       (busy),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out)
    );

    always #5 clk = ~clk;

    // Shared ALU
    always_comb begin
        case (alu_select)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = alu_a & alu_b;
            4'd3:    alu_out = alu_a | alu_b;
            4'd4:    alu_out = alu_a ^ alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic; a fix pass happens on every
    // upper byte that receives a carry/borrow from the bytes below it.
    task automatic model(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] r,
                         output logic c, output int lat);
        logic [16:0] s;
        longint la, lb, m;
        int nfix;
        nfix = 0;
        r = 16'h0;
        c = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: begin
            end
        endcase
        for (int i = 1; i < B; i++) begin
            m  = longint'(1) << (8 * i);
            la = longint'(a) % m;
            lb = longint'(b) % m;
            if (op == 3'd0 && (la + lb) >= m) nfix++;
            if (op == 3'd1 && la < lb) nfix++;
        end
        lat = B + nfix;
    endtask

    // Per-cycle compare against the model and handshake expectations
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, in_flight);
            check("req_ready", req_ready, !in_flight);
            if (!in_flight || in_resp)
                check("alu_quiet", {alu_select, alu_a, alu_b}, 0);
            if (in_resp) begin
                check("rsp_valid", rsp_valid, 1);
                check("rsp_result", rsp_result, exp_res);
                check("rsp_carry", rsp_carry, exp_c);
            end
        end
    end

    task automatic run(input string nm, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] lr, input logic lc,
                       input int ll, input int hold);
        logic [15:0] mr;
        logic mc;
        int ml;
        int cyc;
        model(op, a, b, mr, mc, ml);
        check({nm, "_model_res"}, mr, lr);
        check({nm, "_model_c"}, mc, lc);
        check({nm, "_model_lat"}, ml, ll);
        exp_res = mr;
        exp_c   = mc;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        in_flight = 1'b1;
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, "_latency"}, cyc, ml);
        in_resp = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            check({nm, "_hold_valid"}, rsp_valid, 1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        in_flight = 1'b0;
        in_resp = 1'b0;
        rsp_ready = 1'b0;
        check({nm, "_done"}, {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_out", {rsp_valid, busy, rsp_carry}, 0);
        check("rst_res", rsp_result, 0);
        check("rst_alu", {alu_select, alu_a, alu_b}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", req_ready, 1);

        run("add_ff_01",   3'd0, 16'h00FF, 16'h0001, 16'h0100, 0, 3, 0);
        run("add_ffff_01", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 3, 0);
        run("add_nocarry", 3'd0, 16'h1234, 16'h0101, 16'h1335, 0, 2, 0);
        run("add_msb",     3'd0, 16'h8000, 16'h8000, 16'h0000, 1, 2, 0);
        run("sub_100_1",   3'd1, 16'h0100, 16'h0001, 16'h00FF, 0, 3, 0);
        run("sub_0_1",     3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1, 3, 0);
        run("sub_plain",   3'd1, 16'h5678, 16'h1234, 16'h4444, 0, 2, 0);
        run("xor_hold",    3'd4, 16'h1234, 16'hFF00, 16'hED34, 0, 2, 5);
        run("and",         3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 2, 0);
        run("or",          3'd3, 16'h1200, 16'h0034, 16'h1234, 0, 2, 0);
        run("op5",         3'd5, 16'h1234, 16'h5678, 16'h0000, 0, 2, 0);
        run("op7",         3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 2, 0);

        // Reset while the MSB byte is in its fix pass
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 16'hFFFF;
        req_b = 16'h0001;
        @(posedge clk);
        #1;
        in_flight = 1'b1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("fix_alu_b", alu_b, 8'h01);
        check("fix_alu_a", alu_a, 8'hFF);
        rst_n = 1'b0;
        in_flight = 1'b0;
        #1;
        check("midrst_out", {rsp_valid, busy, rsp_carry}, 0);
        check("midrst_res", rsp_result, 0);
        check("midrst_alu", {alu_select, alu_a, alu_b}, 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_novalid", rsp_valid, 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst_ready", req_ready, 1);
        run("post_rst",    3'd0, 16'h00FF, 16'h0001, 16'h0100, 0, 3, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
